mem_data_resp: RTL and testbench

- Wait-state data-memory responder. It answers the pipeline's MEM-stage load/store port over a request/ready handshake.
- It gives back a configurable number of wait cycles and drives a stall line to the hazard unit. The hazard unit freezes PC, IF_ID, ID_EX, EX_MEM and MEM_WB while the line is high.
- It sits in place of the single-cycle data memory and is the responder end of the datapath's memory interface: address from alu_out_m, write data from haz_b_m, write enable from mem_write_m.

---
 rtl/mem_data_resp_if.sv | 24 ++
 rtl/mem_data_resp.sv | 131 +++++++++++++
 tb/tb_mem_data_resp.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_data_resp_if.sv
// MEM-stage data port bundle between the pipeline (master) and the
// wait-state data memory responder (slave).
//   i_req/i_we/i_addr/i_wdata : access request, driven by the pipeline
//   o_rdata/o_ready/o_stall/o_misalign : response, driven by the responder
interface mem_data_resp_if;
    logic        i_req;
    logic        i_we;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ready;
    logic        o_stall;
    logic        o_misalign;

    modport master (
        output i_req, i_we, i_addr, i_wdata,
        input  o_rdata, o_ready, o_stall, o_misalign
    );

    modport slave (
        input  i_req, i_we, i_addr, i_wdata,
        output o_rdata, o_ready, o_stall, o_misalign
    );
endinterface

// File: rtl/mem_data_resp.sv
// Wait-state data memory answering the MEM-stage load/store port.
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous active-high reset (clears state and memory)
//   i_clk_en   global clock enable; low freezes state and memory
//   bus        slave side of mem_data_resp_if (req/we/addr/wdata in,
//              rdata/ready/stall/misalign out)
module mem_data_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2,
    parameter int ADDR_LSB    = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    mem_data_resp_if.slave   bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            mis_q, mis_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            mem_we;
    logic            stall;
    logic            ready;
    logic            misalign;

    logic [31:0]     mem_q [DEPTH_WORDS];

    // Only the word-index and byte-offset bits matter; upper bits alias.
    logic unused_addr;
    assign unused_addr = ^bus.i_addr;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;
        stall    = 1'b0;
        ready    = 1'b0;
        misalign = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = bus.i_req;
                if (bus.i_req) begin
                    we_d    = bus.i_we;
                    idx_d   = bus.i_addr[ADDR_LSB+AW-1:ADDR_LSB];
                    mis_d   = |bus.i_addr[1:0];
                    wdata_d = bus.i_wdata;
                    cnt_d   = CW'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Latched request is authoritative even if i_req drops.
                    if (we_q) begin
                        mem_we  = ~mis_q;
                        rdata_d = '0;
                    end else begin
                        rdata_d = mis_q ? '0 : mem_q[idx_q];
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                ready    = 1'b1;
                misalign = mis_q;
                // A request still high here belongs to this access.
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            mis_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else if (i_clk_en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            mis_q   <= mis_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_clk_en && mem_we) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign bus.o_rdata    = rdata_q;
    assign bus.o_ready    = ready;
    assign bus.o_stall    = stall;
    assign bus.o_misalign = misalign;

endmodule

// File: tb/tb_mem_data_resp.sv
// Bench for mem_data_resp: directed plan steps plus random accesses
// compared against a word-array model of the memory.
module tb_mem_data_resp;
    localparam int LAT   = 2;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    logic clk_en;

    always #5 clk = ~clk;

    mem_data_resp_if bus ();

    mem_data_resp #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT),
        .ADDR_LSB    (2)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_clk_en (clk_en),
        .bus      (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // Called just after a falling edge; returns just after a falling edge
    // in IDLE with i_req low, so consecutive calls leave one IDLE cycle.
    task automatic access(input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input int hold_at);
        int nstall;
        bit done;
        bit mis;
        int idx;
        logic [31:0] exp_rd;
        nstall = 0;
        done   = 0;
        mis    = (addr[1:0] != 2'b00);
        idx    = int'((addr >> 2) % DEPTH);
        exp_rd = (we || mis) ? 32'h0 : model[idx];
        bus.i_req   = 1'b1;
        bus.i_we    = we;
        bus.i_addr  = addr;
        bus.i_wdata = wd;
        #1;
        for (int k = 0; k < 20 && !done; k++) begin
            if (bus.o_ready === 1'b1) begin
                done = 1;
            end else begin
                chk("stall_high", bus.o_stall, 1);
                nstall++;
                if (k == hold_at) begin
                    clk_en = 1'b0;
                    repeat (5) begin
                        @(negedge clk);
                        #1;
                        chk("hold_stall", bus.o_stall, 1);
                        chk("hold_ready", bus.o_ready, 0);
                    end
                    clk_en = 1'b1;
                end
                @(negedge clk);
                #1;
            end
        end
        chk("ready_seen", done, 1);
        chk("stall_cycles", nstall, LAT + 1);
        chk("rdata", bus.o_rdata, exp_rd);
        chk("misalign_done", bus.o_misalign, mis);
        chk("done_stall", bus.o_stall, 0);
        if (we && !mis) model[idx] = wd;
        @(negedge clk);
        bus.i_req = 1'b0;
        #1;
        chk("idle_ready", bus.o_ready, 0);
        chk("idle_stall", bus.o_stall, 0);
        chk("idle_misalign", bus.o_misalign, 0);
    endtask

    initial begin
        logic [31:0] a;
        rst         = 1'b1;
        clk_en      = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_we    = 1'b0;
        bus.i_addr  = 32'h0;
        bus.i_wdata = 32'h0;
        clear_model();
        #1;
        chk("rst_ready", bus.o_ready, 0);
        chk("rst_stall", bus.o_stall, 0);
        chk("rst_rdata", bus.o_rdata, 0);
        chk("rst_misalign", bus.o_misalign, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;

        access(1'b0, 32'h0000_0010, 32'h0, -1);
        access(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, -1);
        access(1'b0, 32'h0000_0020, 32'h0, -1);
        access(1'b1, 32'h0000_0022, 32'h1234_5678, -1);
        access(1'b0, 32'h0000_0020, 32'h0, -1);
        access(1'b1, 32'h0000_0400, 32'hA5A5_A5A5, -1);
        access(1'b0, 32'h0000_0000, 32'h0, -1);
        access(1'b0, 32'h0000_0020, 32'h0, 1);

        // Reset while a store sits in BUSY.
        bus.i_req   = 1'b1;
        bus.i_we    = 1'b1;
        bus.i_addr  = 32'h0000_0030;
        bus.i_wdata = 32'hFFFF_FFFF;
        @(negedge clk);
        #1;
        chk("busy_stall", bus.o_stall, 1);
        bus.i_req = 1'b0;
        rst       = 1'b1;
        #1;
        chk("rstmid_stall", bus.o_stall, 0);
        chk("rstmid_ready", bus.o_ready, 0);
        chk("rstmid_rdata", bus.o_rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        #1;
        access(1'b0, 32'h0000_0030, 32'h0, -1);
        access(1'b0, 32'h0000_0020, 32'h0, -1);

        for (int n = 0; n < 24; n++) begin
            int idx;
            int off;
            int hold;
            idx  = int'($urandom_range(0, 7));
            off  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            a = ($urandom() & 32'hFFFF_FC00) | (idx << 2) | off;
            access(1'($urandom_range(0, 1)), a, $urandom(), hold);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
